// File: rtl/cache_fill_arbiter.sv
// cache_fill_arbiter
// Shares one external 16-bit word port between the program cache (line
// fills) and the data cache (line fills and write-backs). Each grant runs
// one aligned LINE_WORDS burst. Read words go to the owning cache one cycle
// after their ack. A one-cycle done pulse marks the end of the burst.
module cache_fill_arbiter #(
    parameter int ADDR_WIDTH = 24,
    parameter int LINE_WORDS = 8,
    parameter int WORD_BITS  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    // program cache side
    input  logic                  p_req,
    input  logic [ADDR_WIDTH-1:0] p_addr,
    output logic [15:0]           p_rdata,
    output logic                  p_valid,
    output logic [WORD_BITS-1:0]  p_word,
    output logic                  p_done,
    // data cache side
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [15:0]           d_wdata,
    output logic [WORD_BITS-1:0]  d_widx,
    output logic [15:0]           d_rdata,
    output logic                  d_valid,
    output logic [WORD_BITS-1:0]  d_word,
    output logic                  d_done,
    // external memory side
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ack,
    // status
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Index of the final word in a line, and the mask that clears the word
    // offset so every burst starts on a line boundary.
    localparam logic [WORD_BITS-1:0]  LAST_IDX  = WORD_BITS'(LINE_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~(ADDR_WIDTH'(LINE_WORDS - 1));

    state_t                  r_state;
    state_t                  w_state_next;
    logic [WORD_BITS-1:0]    r_count;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic                    r_we;
    logic                    r_owner;
    logic                    r_last_owner;
    logic [15:0]             r_p_rdata;
    logic [WORD_BITS-1:0]    r_p_word;
    logic                    r_p_valid;
    logic                    r_p_done;
    logic [15:0]             r_d_rdata;
    logic [WORD_BITS-1:0]    r_d_word;
    logic                    r_d_valid;
    logic                    r_d_done;

    logic                    w_grant;
    logic                    w_grant_owner;
    logic                    w_ack;
    logic                    w_last;
    logic [ADDR_WIDTH-1:0]   w_sel_addr;

    // A word completes only while a transfer is actually requested, so
    // stray acks in IDLE/DONE have no effect.
    assign w_ack      = (r_state == ST_BURST) && mem_ack;
    assign w_last     = (r_count == LAST_IDX);
    assign w_sel_addr = w_grant_owner ? d_addr : p_addr;

    // Next-state and grant decision; round-robin favours the side that
    // did not own the previous burst.
    always_comb begin
        w_state_next  = r_state;
        w_grant       = 1'b0;
        w_grant_owner = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (p_req && d_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = ~r_last_owner;
                end else if (p_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = 1'b0;
                end else if (d_req) begin
                    w_grant       = 1'b1;
                    w_grant_owner = 1'b1;
                end else begin
                    w_grant       = 1'b0;
                end
                if (w_grant) begin
                    w_state_next = ST_BURST;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_BURST: begin
                if (w_ack && w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_BURST;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Burst bookkeeping plus registered read forwarding and done pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count      <= '0;
            r_base       <= '0;
            r_we         <= 1'b0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_p_rdata    <= 16'h0000;
            r_p_word     <= '0;
            r_p_valid    <= 1'b0;
            r_p_done     <= 1'b0;
            r_d_rdata    <= 16'h0000;
            r_d_word     <= '0;
            r_d_valid    <= 1'b0;
            r_d_done     <= 1'b0;
        end else begin
            r_p_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_p_done  <= 1'b0;
            r_d_done  <= 1'b0;
            if (w_grant) begin
                r_base       <= w_sel_addr & LINE_MASK;
                r_we         <= w_grant_owner & d_we;
                r_owner      <= w_grant_owner;
                r_last_owner <= w_grant_owner;
                r_count      <= '0;
            end else if (w_ack) begin
                r_count <= r_count + WORD_BITS'(1);
                if (!r_we) begin
                    if (r_owner) begin
                        r_d_rdata <= mem_rdata;
                        r_d_word  <= r_count;
                        r_d_valid <= 1'b1;
                    end else begin
                        r_p_rdata <= mem_rdata;
                        r_p_word  <= r_count;
                        r_p_valid <= 1'b1;
                    end
                end else begin
                    r_p_valid <= 1'b0;
                end
                if (w_last) begin
                    r_p_done <= ~r_owner;
                    r_d_done <= r_owner;
                end else begin
                    r_p_done <= 1'b0;
                end
            end else begin
                r_count <= r_count;
            end
        end
    end

    // The base has its word offset cleared, so OR-ing in the count keeps
    // the address inside the line with no carry into the line bits.
    assign mem_req   = (r_state == ST_BURST);
    assign mem_we    = mem_req & r_we;
    assign mem_addr  = r_base | ADDR_WIDTH'(r_count);
    assign mem_wdata = mem_req ? d_wdata : 16'h0000;
    assign d_widx    = r_count;

    assign busy    = (r_state != ST_IDLE);
    assign owner   = r_owner;
    assign p_rdata = r_p_rdata;
    assign p_word  = r_p_word;
    assign p_valid = r_p_valid;
    assign p_done  = r_p_done;
    assign d_rdata = r_d_rdata;
    assign d_word  = r_d_word;
    assign d_valid = r_d_valid;
    assign d_done  = r_d_done;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter: a per-cycle vector table for a
// program fill, then hand-written sequences for the multi-cycle cases.
module tb_cache_fill_arbiter;

    localparam int AW = 24;
    localparam int WB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          p_req;
    logic [AW-1:0] p_addr;
    logic [15:0]   p_rdata;
    logic          p_valid;
    logic [WB-1:0] p_word;
    logic          p_done;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [15:0]   d_wdata;
    logic [WB-1:0] d_widx;
    logic [15:0]   d_rdata;
    logic          d_valid;
    logic [WB-1:0] d_word;
    logic          d_done;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic [15:0]   mem_rdata;
    logic          mem_ack;
    logic          busy;
    logic          owner;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Memory returns 0xA000 + low address nibble; write-back data is 0x5500 + index.
    assign mem_rdata = 16'hA000 + {12'h000, mem_addr[3:0]};
    assign d_wdata   = 16'h5500 + {13'h0000, d_widx};

    cache_fill_arbiter #(.ADDR_WIDTH(AW), .LINE_WORDS(8), .WORD_BITS(WB)) dut (
        .clk(clk), .reset(reset),
        .p_req(p_req), .p_addr(p_addr), .p_rdata(p_rdata), .p_valid(p_valid),
        .p_word(p_word), .p_done(p_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_widx(d_widx), .d_rdata(d_rdata), .d_valid(d_valid), .d_word(d_word),
        .d_done(d_done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy), .owner(owner)
    );

    typedef struct {
        logic          p_req;
        logic          ack;
        logic          exp_mem_req;
        logic [AW-1:0] exp_addr;
        logic          exp_p_valid;
        logic [WB-1:0] exp_p_word;
        logic [15:0]   exp_p_rdata;
        logic          exp_p_done;
        logic          exp_busy;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic pr, input logic ak, input logic mr,
                                input logic [AW-1:0] ad, input logic pv,
                                input logic [WB-1:0] pw, input logic [15:0] pd,
                                input logic pdn, input logic by);
        vec_t v;
        v.p_req = pr; v.ack = ak; v.exp_mem_req = mr; v.exp_addr = ad;
        v.exp_p_valid = pv; v.exp_p_word = pw; v.exp_p_rdata = pd;
        v.exp_p_done = pdn; v.exp_busy = by;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; p_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // Runs a burst that is in its first BURST cycle with mem_ack held high,
    // checking addresses and forwarded words; drops the owner's request at
    // done and leaves the bench in the following IDLE cycle.
    task automatic drain(input bit own, input logic [AW-1:0] base, input bit drop_early);
        int nw;
        int nv;
        bit seen_done;
        bit stray;
        nw = 0; nv = 0; seen_done = 1'b0; stray = 1'b0;
        for (int c = 0; c < 40 && !seen_done; c++) begin
            if (mem_req) begin
                check("burst_addr", 32'(mem_addr), 32'(base + AW'(nw)));
                check("burst_we", 32'(mem_we), 32'd0);
                nw++;
                if (drop_early && nw == 2) p_req = 1'b0;
            end
            if (own ? p_valid : d_valid) stray = 1'b1;
            if (own ? p_done : d_done) stray = 1'b1;
            if (own ? d_valid : p_valid) begin
                check("rd_word", 32'(own ? d_word : p_word), 32'(nv));
                check("rd_data", 32'(own ? d_rdata : p_rdata),
                      32'(16'hA000 + 16'(base[3:0]) + 16'(nv)));
                nv++;
            end
            if (own ? d_done : p_done) begin
                seen_done = 1'b1;
                check("burst_words", 32'(nw), 32'd8);
                check("burst_valids", 32'(nv), 32'd8);
                if (own) d_req = 1'b0;
                else p_req = 1'b0;
            end
            step();
        end
        check("burst_done_seen", 32'(seen_done), 32'd1);
        check("nonowner_strobe", 32'(stray), 32'd0);
    endtask

    initial begin
        p_addr = '0; d_addr = '0;
        do_reset();

        // Reset state.
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_valids", 32'({p_valid, d_valid, p_done, d_done}), 32'd0);
        check("rst_rdata", 32'({p_rdata, d_rdata}), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);

        // Program fill table: spurious ack in IDLE, 8 words, done, release.
        vecs[0] = mk(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);
        vecs[1] = mk(1'b1, 1'b1, 1'b1, 24'h001230, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1);
        for (int k = 2; k <= 8; k++)
            vecs[k] = mk(1'b1, 1'b1, 1'b1, 24'h001230 + AW'(k - 1), 1'b1,
                         WB'(k - 2), 16'hA000 + 16'(k - 2), 1'b0, 1'b1);
        vecs[9]  = mk(1'b1, 1'b1, 1'b0, 24'h0, 1'b1, 3'd7, 16'hA007, 1'b1, 1'b1);
        vecs[10] = mk(1'b0, 1'b1, 1'b0, 24'h0, 1'b0, 3'd0, 16'h0, 1'b0, 1'b0);

        p_addr = 24'h001235;
        for (int i = 0; i < 11; i++) begin
            p_req   = vecs[i].p_req;
            mem_ack = vecs[i].ack;
            step();
            check("tbl_mem_req", 32'(mem_req), 32'(vecs[i].exp_mem_req));
            if (vecs[i].exp_mem_req) begin
                check("tbl_mem_addr", 32'(mem_addr), 32'(vecs[i].exp_addr));
                check("tbl_mem_we", 32'(mem_we), 32'd0);
            end
            check("tbl_p_valid", 32'(p_valid), 32'(vecs[i].exp_p_valid));
            if (vecs[i].exp_p_valid) begin
                check("tbl_p_word", 32'(p_word), 32'(vecs[i].exp_p_word));
                check("tbl_p_rdata", 32'(p_rdata), 32'(vecs[i].exp_p_rdata));
            end
            check("tbl_p_done", 32'(p_done), 32'(vecs[i].exp_p_done));
            check("tbl_busy", 32'(busy), 32'(vecs[i].exp_busy));
            check("tbl_d_valid", 32'({d_valid, d_done}), 32'd0);
        end

        // Data write-back with ack gaps; d_we flips mid-burst and is ignored.
        d_req = 1'b1; d_we = 1'b1; d_addr = 24'h00FFF8; mem_ack = 1'b0;
        step();
        check("wb_grant", 32'({busy, owner}), 32'b11);
        for (int w = 0; w < 8; w++) begin
            if (w == 4) d_we = 1'b0;
            mem_ack = 1'b1;
            check("wb_mem_req", 32'(mem_req), 32'd1);
            check("wb_mem_we", 32'(mem_we), 32'd1);
            check("wb_addr", 32'(mem_addr), 32'(24'h00FFF8 + AW'(w)));
            check("wb_wdata", 32'(mem_wdata), 32'(16'h5500 + 16'(w)));
            step();
            if (w < 7) begin
                mem_ack = 1'b0;
                check("wb_hold_addr", 32'(mem_addr), 32'(24'h00FFF8 + AW'(w + 1)));
                check("wb_no_valid", 32'({d_valid, d_done}), 32'd0);
                step();
            end
        end
        check("wb_done", 32'({d_done, d_valid, mem_req, p_done}), 32'b1000);
        d_req = 1'b0; d_we = 1'b0;
        step();
        check("wb_idle", 32'(busy), 32'd0);

        // Simultaneous requests after reset: program first, data 2 cycles later.
        do_reset();
        p_addr = 24'h002000; d_addr = 24'h003000; d_we = 1'b0;
        p_req = 1'b1; d_req = 1'b1; mem_ack = 1'b1;
        step();
        check("sim_first_owner", 32'({busy, owner}), 32'b10);
        drain(1'b0, 24'h002000, 1'b0);
        check("sim_gap_idle", 32'(busy), 32'd0);
        step();
        check("sim_second_owner", 32'({busy, owner}), 32'b11);
        check("sim_second_addr", 32'(mem_addr), 32'h003000);
        drain(1'b1, 24'h003000, 1'b0);

        // Solo program burst, then a pair: round-robin now picks data.
        p_addr = 24'h004000; p_req = 1'b1;
        step();
        drain(1'b0, 24'h004000, 1'b0);
        d_addr = 24'h005000; p_req = 1'b1; d_req = 1'b1;
        step();
        check("rr_pair_owner", 32'({busy, owner}), 32'b11);
        drain(1'b1, 24'h005000, 1'b0);
        step();
        check("rr_pending_prog", 32'({busy, owner}), 32'b10);
        drain(1'b0, 24'h004000, 1'b0);

        // Top line stays inside the aligned line.
        p_addr = 24'hFFFFFF; p_req = 1'b1;
        step();
        drain(1'b0, 24'hFFFFF8, 1'b0);

        // Reset after the 3rd ack of a data fill.
        d_addr = 24'h000400; d_we = 1'b0; d_req = 1'b1; mem_ack = 1'b1;
        step();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("rst_mid_mem_req", 32'(mem_req), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_strobes", 32'({d_done, d_valid}), 32'd0);
        reset = 1'b0; d_req = 1'b0;
        step();
        check("rst_mid_after", 32'({busy, d_done, d_valid}), 32'd0);
        p_addr = 24'h000100; p_req = 1'b1;
        step();
        check("rst_mid_regrant", 32'({busy, owner}), 32'b10);
        drain(1'b0, 24'h000100, 1'b0);

        // Program request dropped after two words still completes.
        p_addr = 24'h000200; p_req = 1'b1;
        step();
        drain(1'b0, 24'h000200, 1'b1);
        check("drop_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_arbiter.md
Name: cache_fill_arbiter

Overview:
- Shares the single external 16-bit memory port between the program cache (line fills) and the data cache (line fills and line write-backs).
- Sequences one fixed-length burst per grant and forwards read words to the owning cache.
- Signals burst completion so the cache can release the CPU miss stall (p_cache_miss / d_cache_read_miss / d_cache_write_miss).
- Sits between both caches and the external memory controller, outside the CPU core.

Parameters:
ADDR_WIDTH, 24, external word-address width
LINE_WORDS, 8, words per cache line; power of two, at least 2
WORD_BITS, 3, log2(LINE_WORDS)

Ports:
clk  in  1  system clock; all state changes on the rising edge
reset  in  1  synchronous, active-high reset
p_req  in  1  program cache fill request; held until p_done
p_addr  in  ADDR_WIDTH  program line address; low WORD_BITS ignored
p_rdata  out  16  fill word to program cache
p_valid  out  1  p_rdata/p_word valid strobe
p_word  out  WORD_BITS  index of p_rdata within the line
p_done  out  1  one-cycle burst-complete pulse
d_req  in  1  data cache request; held until d_done
d_we  in  1  1 = write-back line, 0 = fill line; stable while d_req
d_addr  in  ADDR_WIDTH  data line address; low WORD_BITS ignored
d_wdata  in  16  write-back word selected by d_widx
d_widx  out  WORD_BITS  index of the write word currently presented
d_rdata  out  16  fill word to data cache
d_valid  out  1  d_rdata/d_word valid strobe
d_word  out  WORD_BITS  index of d_rdata
d_done  out  1  one-cycle burst-complete pulse
mem_req  out  1  word transfer request
mem_we  out  1  write when high
mem_addr  out  ADDR_WIDTH  word address
mem_wdata  out  16  write data (d_wdata passthrough)
mem_rdata  in  16  read data; valid in the mem_ack cycle
mem_ack  in  1  word completes when mem_req & mem_ack
busy  out  1  high in any non-IDLE state
owner  out  1  0 = program, 1 = data; meaningful while busy

Behaviour:
- Reset (synchronous): state IDLE, count 0, last_owner 1.
  - All strobes, mem_req, mem_we, busy, p_done and d_done are 0.
  - Data outputs are 0.
- States: IDLE, BURST, DONE.
- IDLE:
  - Only p_req: grant program.
  - Only d_req: grant data.
  - Both: grant the requester not equal to last_owner (round-robin; after reset, program wins).
  - On grant: latch base = addr with the low WORD_BITS cleared, latch we (d_we for data, 0 for program), set owner and last_owner, set count 0, go to BURST.
- BURST:
  - mem_req = 1, mem_we = latched we, mem_addr = base + count.
  - d_widx = count; mem_wdata = d_wdata combinationally.
  - On mem_ack, count increments. If count was LINE_WORDS-1, go to DONE.
  - Without mem_ack, all outputs hold and there is no timeout.
- Read forwarding has 1-cycle latency: at the ack edge, the owner's rdata <= mem_rdata and word <= count, and the owner's valid pulses high for the following cycle. The non-owner's valid stays 0.
- Write bursts produce no valid strobes.
- DONE: lasts one cycle.
  - The owner's done = 1; mem_req = 0.
  - For reads, the last word's valid coincides with done.
  - Next state is IDLE.
- Requester must drop req at the edge where it samples done high. IDLE therefore never re-grants a finished request. A new request is granted on the first IDLE cycle (2-cycle gap between consecutive bursts).
- Burst throughput: one word per cycle when mem_ack is held high. LINE_WORDS-word burst = LINE_WORDS BURST cycles + 1 DONE cycle.
- Address arithmetic: base + count with no carry into bits above WORD_BITS. Addressing stays within the aligned line, so the top line (base all ones) does not wrap to 0.
- mem_ack while mem_req = 0 (IDLE/DONE): ignored.
- Requester dropping req mid-burst: the burst still runs to completion and done still pulses (no abort).
- Request rising during another's burst: held pending; granted in the next IDLE.
- Reset mid-burst: the next edge forces IDLE. mem_req drops that cycle; no done or valid pulse is emitted.
- d_we changing mid-burst: ignored (latched at grant).

Test Plan:
- Program fill:
  - Stimulus: reset, p_req=1, p_addr=0x001235, mem_ack tied 1, mem_rdata = 0xA000+address low nibble.
  - Required: mem_addr 0x001230..0x001237 on 8 consecutive cycles, mem_we=0.
  - Required: p_valid on 8 cycles with p_word 0..7 and p_rdata 0xA000..0xA007; p_done together with the last valid; d_valid never 1.
- Data write-back with ack gaps:
  - Stimulus: d_req=1, d_we=1, d_addr=0x00FFF8, d_wdata = 0x5500+d_widx, mem_ack toggling 1,0.
  - Required: 8 writes, mem_wdata 0x5500..0x5507 at addresses 0x00FFF8..0x00FFFF; d_done after the 8th ack; no d_valid.
- Simultaneous requests:
  - Stimulus: p_req and d_req rise in the same cycle after reset, both fills.
  - Required: program burst first; after p_done, data burst starts 2 cycles later.
  - Required: a further simultaneous pair is granted to data.
- Top line:
  - Stimulus: p_addr=0xFFFFFF.
  - Required: addresses 0xFFFFF8..0xFFFFFF; no 0x000000 access.
- Reset mid-burst:
  - Stimulus: assert reset after the 3rd ack of a data fill.
  - Required: mem_req=0 on the next cycle; no d_done; busy=0; a new p_req is granted normally afterwards.
- Spurious ack / dropped req:
  - Stimulus: mem_ack=1 while IDLE; p_req dropped after 2 words.
  - Required: no state change while IDLE; the program burst still completes all 8 words with p_done.
